// File: rtl/cordic_stage_hs.sv
// One CORDIC micro-rotation stage. Latency is 1 cycle. A 2-entry skid buffer gives
// a registered in_ready, so upstream sees full backpressure.
module cordic_stage_hs #(
   parameter int XY_WIDTH    = 17,
   parameter int ANGLE_WIDTH = 18,
   parameter int SHIFT_NUM   = 0,
   parameter int STEP        = 32768,
   parameter int TAG_WIDTH   = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   in_mode,
   input  logic [XY_WIDTH-1:0]    in_x,
   input  logic [XY_WIDTH-1:0]    in_y,
   input  logic [ANGLE_WIDTH-1:0] in_z,
   input  logic [TAG_WIDTH-1:0]   in_tag,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   out_mode,
   output logic [XY_WIDTH-1:0]    out_x,
   output logic [XY_WIDTH-1:0]    out_y,
   output logic [ANGLE_WIDTH-1:0] out_z,
   output logic [TAG_WIDTH-1:0]   out_tag,
   output logic [1:0]             occupancy
);

   typedef struct packed {
      logic                   mode;
      logic [XY_WIDTH-1:0]    x;
      logic [XY_WIDTH-1:0]    y;
      logic [ANGLE_WIDTH-1:0] z;
      logic [TAG_WIDTH-1:0]   tag;
   } sample_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   localparam logic signed [ANGLE_WIDTH-1:0] STEP_Z = ANGLE_WIDTH'(STEP);

   logic signed [XY_WIDTH-1:0]    x_s, y_s, x_sh, y_sh;
   logic signed [ANGLE_WIDTH-1:0] z_s;
   logic                          d_pos;
   logic                          accept, pop;
   sample_t                       calc, out_r, skid_r;
   state_t                        state;

   // Results are computed on the input side so both buffer entries hold finished samples.
   always_comb begin
      x_s   = in_x;
      y_s   = in_y;
      z_s   = in_z;
      x_sh  = x_s >>> SHIFT_NUM;
      y_sh  = y_s >>> SHIFT_NUM;
      d_pos = in_mode ? y_s[XY_WIDTH-1] : ~z_s[ANGLE_WIDTH-1];
      calc      = '0;
      calc.mode = in_mode;
      calc.tag  = in_tag;
      calc.x    = d_pos ? (x_s - y_sh) : (x_s + y_sh);
      calc.y    = d_pos ? (y_s + x_sh) : (y_s - x_sh);
      calc.z    = d_pos ? (z_s - STEP_Z) : (z_s + STEP_Z);
   end

   assign accept = in_valid & in_ready;
   assign pop    = out_valid & out_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= EMPTY;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_r     <= '0;
         skid_r    <= '0;
      end else begin
         case (state)
            EMPTY: begin
               in_ready <= 1'b1;
               if (accept) begin
                  out_r     <= calc;
                  out_valid <= 1'b1;
                  state     <= ONE;
               end
            end
            ONE: begin
               if (accept && !pop) begin
                  skid_r   <= calc;
                  in_ready <= 1'b0;
                  state    <= FULL;
               end else if (accept && pop) begin
                  out_r <= calc;
               end else if (pop) begin
                  out_valid <= 1'b0;
                  state     <= EMPTY;
               end
            end
            FULL: begin
               if (pop) begin
                  out_r    <= skid_r;
                  in_ready <= 1'b1;
                  state    <= ONE;
               end
            end
            default: begin
               state     <= EMPTY;
               in_ready  <= 1'b0;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign out_mode  = out_r.mode;
   assign out_x     = out_r.x;
   assign out_y     = out_r.y;
   assign out_z     = out_r.z;
   assign out_tag   = out_r.tag;
   assign occupancy = state;

endmodule

// File: tb/tb_cordic_stage_hs.sv
// Directed and streaming checks for cordic_stage_hs (shift 0 and shift 2 instances).
module tb_cordic_stage_hs;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic               in_valid = 1'b0, in_mode = 1'b0, out_ready = 1'b0;
   logic signed [16:0] in_x = '0, in_y = '0;
   logic signed [17:0] in_z = '0;
   logic [3:0]         in_tag = '0;
   logic               in_ready, out_valid, out_mode;
   logic signed [16:0] out_x, out_y;
   logic signed [17:0] out_z;
   logic [3:0]         out_tag;
   logic [1:0]         occupancy;

   logic               u2_in_valid = 1'b0, u2_out_ready = 1'b1;
   logic signed [16:0] u2_in_x = '0, u2_in_y = '0;
   logic signed [17:0] u2_in_z = '0;
   logic               u2_in_ready, u2_out_valid, u2_out_mode;
   logic signed [16:0] u2_out_x, u2_out_y;
   logic signed [17:0] u2_out_z;
   logic [3:0]         u2_out_tag;
   logic [1:0]         u2_occupancy;

   int checks = 0;
   int errors = 0;

   cordic_stage_hs #(.XY_WIDTH(17), .ANGLE_WIDTH(18), .SHIFT_NUM(0), .STEP(32768), .TAG_WIDTH(4)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
      .in_x(in_x), .in_y(in_y), .in_z(in_z), .in_tag(in_tag), .out_valid(out_valid),
      .out_ready(out_ready), .out_mode(out_mode), .out_x(out_x), .out_y(out_y), .out_z(out_z),
      .out_tag(out_tag), .occupancy(occupancy));

   cordic_stage_hs #(.XY_WIDTH(17), .ANGLE_WIDTH(18), .SHIFT_NUM(2), .STEP(10221), .TAG_WIDTH(4)) dut2 (
      .clk(clk), .reset(reset), .in_valid(u2_in_valid), .in_ready(u2_in_ready), .in_mode(1'b0),
      .in_x(u2_in_x), .in_y(u2_in_y), .in_z(u2_in_z), .in_tag(4'd9), .out_valid(u2_out_valid),
      .out_ready(u2_out_ready), .out_mode(u2_out_mode), .out_x(u2_out_x), .out_y(u2_out_y),
      .out_z(u2_out_z), .out_tag(u2_out_tag), .occupancy(u2_occupancy));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic m, input logic signed [16:0] x, input logic signed [16:0] y,
                        input logic signed [17:0] z, input logic [3:0] t);
      in_valid = 1'b1; in_mode = m; in_x = x; in_y = y; in_z = z; in_tag = t;
   endtask

   // Shift-0, STEP=32768 reference written with plain integer arithmetic.
   task automatic model(input logic m, input logic signed [16:0] x, input logic signed [16:0] y,
                        input logic signed [17:0] z, output logic signed [16:0] ex,
                        output logic signed [16:0] ey, output logic signed [17:0] ez);
      int d, xi, yi, zi;
      xi = x; yi = y; zi = z;
      if (m) d = (yi < 0) ? 1 : -1;
      else   d = (zi >= 0) ? 1 : -1;
      ex = 17'(xi - d * yi);
      ey = 17'(yi + d * xi);
      ez = 18'(zi - d * 32768);
   endtask

   logic               pm;
   logic signed [16:0] px, py, ex, ey;
   logic signed [17:0] pz, ez;
   logic [3:0]         pt;

   initial begin
      step(); step();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_occupancy", occupancy, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_x", out_x, 0);
      chk("rst_out_z", out_z, 0);
      chk("rst_out_tag", out_tag, 0);
      reset = 1'b0;
      step();
      chk("in_ready_after_rst", in_ready, 1);

      // Rotation
      out_ready = 1'b1;
      drive(1'b0, 1000, 0, 10000, 4'd5);
      step();
      in_valid = 1'b0;
      chk("rot_valid", out_valid, 1);
      chk("rot_x", out_x, 1000);
      chk("rot_y", out_y, 1000);
      chk("rot_z", out_z, -22768);
      chk("rot_tag", out_tag, 5);
      chk("rot_mode", out_mode, 0);
      chk("rot_occ", occupancy, 1);
      step();
      chk("rot_drain_valid", out_valid, 0);
      chk("rot_drain_occ", occupancy, 0);

      // Vectoring, both signs of y, back to back
      drive(1'b1, 1000, -500, 0, 4'd6);
      step();
      chk("vec_neg_x", out_x, 1500);
      chk("vec_neg_y", out_y, 500);
      chk("vec_neg_z", out_z, -32768);
      chk("vec_neg_mode", out_mode, 1);
      drive(1'b1, 1000, 500, 0, 4'd7);
      step();
      in_valid = 1'b0;
      chk("vec_pos_x", out_x, 1500);
      chk("vec_pos_y", out_y, -500);
      chk("vec_pos_z", out_z, 32768);
      chk("vec_pos_tag", out_tag, 7);
      step();

      // Floor rounding on the shift-2 instance
      u2_in_valid = 1'b1; u2_in_x = 100; u2_in_y = -7; u2_in_z = 0;
      step();
      u2_in_valid = 1'b0;
      chk("rnd_valid", u2_out_valid, 1);
      chk("rnd_x", u2_out_x, 102);
      chk("rnd_y", u2_out_y, 18);
      chk("rnd_z", u2_out_z, -10221);
      chk("rnd_tag", u2_out_tag, 9);
      step();

      // Backpressure: A, B accepted, C held upstream
      out_ready = 1'b0;
      drive(1'b0, 10, 0, 0, 4'd1);
      step();
      chk("bp_a_occ", occupancy, 1);
      chk("bp_a_rdy", in_ready, 1);
      drive(1'b0, 20, 0, 0, 4'd2);
      step();
      chk("bp_b_occ", occupancy, 2);
      chk("bp_b_rdy", in_ready, 0);
      drive(1'b0, 30, 0, 0, 4'd3);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("bp_stall_occ", occupancy, 2);
         chk("bp_stall_rdy", in_ready, 0);
         chk("bp_stall_valid", out_valid, 1);
         chk("bp_stall_x", out_x, 10);
         chk("bp_stall_y", out_y, 10);
         chk("bp_stall_tag", out_tag, 1);
      end
      out_ready = 1'b1;
      step();
      chk("bp_out_b_tag", out_tag, 2);
      chk("bp_out_b_x", out_x, 20);
      chk("bp_out_b_occ", occupancy, 1);
      chk("bp_out_b_rdy", in_ready, 1);
      step();
      in_valid = 1'b0;
      chk("bp_out_c_tag", out_tag, 3);
      chk("bp_out_c_x", out_x, 30);
      chk("bp_out_c_occ", occupancy, 1);
      step();
      chk("bp_empty_valid", out_valid, 0);
      chk("bp_empty_occ", occupancy, 0);

      // Streaming, first sample exercises wrap-around
      pm = 1'b0; px = 65535; py = 65535; pz = 0; pt = 4'd0;
      for (int i = 0; i < 100; i++) begin
         drive(pm, px, py, pz, pt);
         step();
         model(pm, px, py, pz, ex, ey, ez);
         if (i == 0) chk("wrap_y_hand", out_y, -2);
         chk("str_rdy", in_ready, 1);
         chk("str_occ", occupancy, 1);
         chk("str_valid", out_valid, 1);
         chk("str_x", out_x, ex);
         chk("str_y", out_y, ey);
         chk("str_z", out_z, ez);
         chk("str_tag", out_tag, pt);
         chk("str_mode", out_mode, pm);
         pm = 1'($urandom); px = 17'($urandom); py = 17'($urandom);
         pz = 18'($urandom); pt = 4'($urandom);
      end
      in_valid = 1'b0;
      step();
      chk("str_drain_occ", occupancy, 0);

      // Reset while full
      out_ready = 1'b0;
      drive(1'b0, 40, 0, 0, 4'd4);
      step();
      drive(1'b0, 50, 0, 0, 4'd5);
      step();
      in_valid = 1'b0;
      chk("rf_pre_occ", occupancy, 2);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("rf_valid", out_valid, 0);
      chk("rf_occ", occupancy, 0);
      chk("rf_rdy", in_ready, 0);
      chk("rf_x", out_x, 0);
      step();
      chk("rf_rdy_rise", in_ready, 1);
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rf_no_stale", out_valid, 0);
         chk("rf_occ_idle", occupancy, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
